// File: rtl/rob_commit_buffer.sv
// ---------------------------------------------------------------------------
// rob_commit_buffer
//
// In-order reorder buffer. Dispatch allocates entries at the tail, execute
// completes them out of order by tag, and at most one entry retires per cycle
// from the head, strictly in program order. The retire drives a registered
// write port into the architectural register file. A synchronous flush
// discards everything in flight.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   alloc_valid       dispatch requests an entry
//   alloc_has_dst     instruction writes a destination register
//   alloc_dst_index   destination architectural register
//   alloc_ready       an entry is free (current state, no commit look-ahead)
//   alloc_tag         tag given to the current allocation (tail index)
//   wb_valid/wb_tag/wb_val   execute completion for entry wb_tag
//   flush             drop all in-flight entries at the next edge
//   rob_valid         one-cycle commit write pulse (x0 writes suppressed)
//   rob_dst_val       committed value (holds between commits)
//   rob_dst_index     committed destination (holds between commits)
//   rob_count         number of occupied entries
// ---------------------------------------------------------------------------
module rob_commit_buffer #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_AREGS   = 32,
  localparam int TAG_W      = $clog2(NUM_ENTRIES),
  localparam int AREG_W     = $clog2(NUM_AREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic              alloc_has_dst,
  input  logic [AREG_W-1:0] alloc_dst_index,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [31:0]       wb_val,
  input  logic              flush,
  output logic              rob_valid,
  output logic [31:0]       rob_dst_val,
  output logic [AREG_W-1:0] rob_dst_index,
  output logic [TAG_W:0]    rob_count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(NUM_ENTRIES);
  localparam logic [TAG_W:0] PTR_ONE    = (TAG_W+1)'(1);

  // Control state: needs reset.
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] done_q, done_d;
  logic [TAG_W:0]         head_q, head_d;
  logic [TAG_W:0]         tail_q, tail_d;
  logic                   rob_valid_q, rob_valid_d;
  logic [31:0]            rob_dst_val_q, rob_dst_val_d;
  logic [AREG_W-1:0]      rob_dst_index_q, rob_dst_index_d;

  // Payload storage: only meaningful while the matching valid/done bit is
  // set, so it carries no reset.
  logic [NUM_ENTRIES-1:0] has_dst_mem;
  logic [AREG_W-1:0]      dst_mem   [NUM_ENTRIES];
  logic [31:0]            value_mem [NUM_ENTRIES];

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             alloc_fire;
  logic             wb_fire;
  logic             commit;

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];

  // Wrap bits make tail - head the exact occupancy, including the full case.
  assign rob_count   = tail_q - head_q;
  assign alloc_ready = (rob_count != FULL_COUNT);
  assign alloc_tag   = tail_idx;

  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign wb_fire    = wb_valid && valid_q[wb_tag] && !flush;
  assign commit     = valid_q[head_idx] && done_q[head_idx] && !flush;

  always_comb begin
    valid_d         = valid_q;
    done_d          = done_q;
    head_d          = head_q;
    tail_d          = tail_q;
    rob_valid_d     = 1'b0;
    rob_dst_val_d   = rob_dst_val_q;
    rob_dst_index_d = rob_dst_index_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + PTR_ONE;
      end
      if (wb_fire) begin
        done_d[wb_tag] = 1'b1;
      end
      // Commit reads the payload of the head as it was before this edge, so
      // a same-cycle writeback to another entry never disturbs it.
      if (commit) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_ONE;
        rob_valid_d       = has_dst_mem[head_idx] && (dst_mem[head_idx] != '0);
        rob_dst_val_d     = value_mem[head_idx];
        rob_dst_index_d   = dst_mem[head_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      rob_valid_q     <= 1'b0;
      rob_dst_val_q   <= '0;
      rob_dst_index_q <= '0;
    end else begin
      valid_q         <= valid_d;
      done_q          <= done_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      rob_valid_q     <= rob_valid_d;
      rob_dst_val_q   <= rob_dst_val_d;
      rob_dst_index_q <= rob_dst_index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_dst_mem[tail_idx] <= alloc_has_dst;
      dst_mem[tail_idx]     <= alloc_dst_index;
    end
    if (wb_fire) begin
      value_mem[wb_tag] <= wb_val;
    end
  end

  assign rob_valid     = rob_valid_q;
  assign rob_dst_val   = rob_dst_val_q;
  assign rob_dst_index = rob_dst_index_q;

endmodule

// File: tb/tb_rob_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_rob_commit_buffer
//
// Scoreboard bench: each allocation that should produce an architectural
// write pushes its (index, value) onto a queue; a negedge monitor pops and
// compares on every rob_valid pulse.
// ---------------------------------------------------------------------------
module tb_rob_commit_buffer;

  localparam int N  = 16;
  localparam int TW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_has_dst = 1'b0;
  logic [AW-1:0] alloc_dst_index = '0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          wb_valid = 1'b0;
  logic [TW-1:0] wb_tag = '0;
  logic [31:0]   wb_val = '0;
  logic          flush = 1'b0;
  logic          rob_valid;
  logic [31:0]   rob_dst_val;
  logic [AW-1:0] rob_dst_index;
  logic [TW:0]   rob_count;

  always #5 clk = ~clk;

  rob_commit_buffer #(.NUM_ENTRIES(N), .NUM_AREGS(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_has_dst   (alloc_has_dst),
    .alloc_dst_index (alloc_dst_index),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .wb_valid        (wb_valid),
    .wb_tag          (wb_tag),
    .wb_val          (wb_val),
    .flush           (flush),
    .rob_valid       (rob_valid),
    .rob_dst_val     (rob_dst_val),
    .rob_dst_index   (rob_dst_index),
    .rob_count       (rob_count)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   val;
  } commit_t;

  commit_t     exp_q[$];
  commit_t     mon_e;
  logic [31:0] tb_val [N];
  int          exp_tail = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: one line per retired architectural write.
  always @(negedge clk) begin
    if (!rst && rob_valid) begin
      $display("commit idx=%0d val=0x%08h", rob_dst_index, rob_dst_val);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_commit", 32'(rob_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("commit_idx", 32'(rob_dst_index), 32'(mon_e.idx));
        check_eq("commit_val", rob_dst_val, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [AW-1:0] dst, input logic hd, input logic [31:0] val);
    check_eq("alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("alloc_tag", 32'(alloc_tag), 32'(exp_tail));
    $display("alloc tag=%0d dst=%0d has_dst=%0d val=0x%08h", exp_tail, dst, hd, val);
    alloc_valid     = 1'b1;
    alloc_has_dst   = hd;
    alloc_dst_index = dst;
    tb_val[exp_tail] = val;
    if (hd && dst != '0) exp_q.push_back(commit_t'{idx: dst, val: val});
    tick();
    alloc_valid = 1'b0;
    exp_tail = (exp_tail + 1) % N;
  endtask

  task automatic do_wb(input int tag);
    $display("wb tag=%0d val=0x%08h", tag, tb_val[tag]);
    wb_valid = 1'b1;
    wb_tag   = TW'(tag);
    wb_val   = tb_val[tag];
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 64 && rob_count != '0; i++) tick();
    check_eq("drain_count", 32'(rob_count), 32'd0);
  endtask

  // Asynchronous reset: the count must clear before any clock edge arrives.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("async_rst_count", 32'(rob_count), 32'd0);
    check_eq("async_rst_ready", 32'(alloc_ready), 32'd1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_tail = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    // 1: reset then idle
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_dst_val", rob_dst_val, 32'd0);
    check_eq("rst_dst_index", 32'(rob_dst_index), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check_eq("idle_count", 32'(rob_count), 32'd0);
      check_eq("idle_ready", 32'(alloc_ready), 32'd1);
      check_eq("idle_tag", 32'(alloc_tag), 32'd0);
      check_eq("idle_rob_valid", 32'(rob_valid), 32'd0);
      tick();
    end

    // 2: out-of-order writeback, in-order commit on consecutive cycles
    do_alloc(5'd5, 1'b1, 32'h11);
    do_alloc(5'd6, 1'b1, 32'h22);
    do_alloc(5'd7, 1'b1, 32'h33);
    do_wb(2);
    check_eq("ooo_no_commit_a", 32'(rob_valid), 32'd0);
    do_wb(0);
    check_eq("ooo_no_commit_b", 32'(rob_valid), 32'd0);
    do_wb(1);
    check_eq("ooo_commit0", 32'(rob_valid), 32'd1);
    tick();
    check_eq("ooo_commit1", 32'(rob_valid), 32'd1);
    tick();
    check_eq("ooo_commit2", 32'(rob_valid), 32'd1);
    tick();
    check_eq("ooo_after", 32'(rob_valid), 32'd0);
    check_eq("ooo_count", 32'(rob_count), 32'd0);

    // 3: fill, then commit and allocate around the full boundary
    do_reset();
    for (int i = 0; i < N; i++) do_alloc(AW'(i + 1), 1'b1, 32'h100 + 32'(i));
    check_eq("full_count", 32'(rob_count), 32'd16);
    check_eq("full_ready", 32'(alloc_ready), 32'd0);
    alloc_valid     = 1'b1;
    alloc_has_dst   = 1'b1;
    alloc_dst_index = 5'd20;
    wb_valid = 1'b1;
    wb_tag   = '0;
    wb_val   = tb_val[0];
    tick();
    wb_valid = 1'b0;
    check_eq("full_hold_count", 32'(rob_count), 32'd16);
    check_eq("full_hold_ready", 32'(alloc_ready), 32'd0);
    tick();
    check_eq("commit_cycle_count", 32'(rob_count), 32'd15);
    check_eq("commit_cycle_ready", 32'(alloc_ready), 32'd1);
    check_eq("wrap_tag", 32'(alloc_tag), 32'd0);
    check_eq("commit_cycle_valid", 32'(rob_valid), 32'd1);
    tb_val[0] = 32'h200;
    exp_q.push_back(commit_t'{idx: 5'd20, val: 32'h200});
    $display("alloc tag=0 dst=20 has_dst=1 val=0x00000200");
    tick();
    alloc_valid = 1'b0;
    exp_tail = 1;
    check_eq("refill_count", 32'(rob_count), 32'd16);
    for (int i = 1; i < N; i++) do_wb(i);
    do_wb(0);
    wait_empty();

    // 4: one in flight at a time, tags wrap several times
    for (int i = 0; i < 40; i++) begin
      t = exp_tail;
      do_alloc(AW'((i % 31) + 1), 1'b1, $urandom);
      do_wb(t);
      wait_empty();
    end

    // 5: x0 and no-destination instructions retire silently
    t = exp_tail;
    do_alloc(5'd0, 1'b1, 32'hAAAA);
    do_alloc(5'd9, 1'b0, 32'hBBBB);
    check_eq("silent_count", 32'(rob_count), 32'd2);
    do_wb(t);
    do_wb((t + 1) % N);
    wait_empty();

    // 6: flush with alloc and writeback in the same cycle, head already done
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(AW'(10 + i), 1'b1, 32'h600 + 32'(i));
    check_eq("pre_flush_count", 32'(rob_count), 32'd5);
    do_wb(0);
    flush           = 1'b1;
    alloc_valid     = 1'b1;
    alloc_has_dst   = 1'b1;
    alloc_dst_index = 5'd3;
    wb_valid = 1'b1;
    wb_tag   = 4'd1;
    wb_val   = 32'h77;
    $display("flush with alloc and wb tag=1");
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    wb_valid = 1'b0;
    exp_q.delete();
    exp_tail = 0;
    check_eq("flush_count", 32'(rob_count), 32'd0);
    check_eq("flush_tag", 32'(alloc_tag), 32'd0);
    check_eq("flush_rob_valid", 32'(rob_valid), 32'd0);
    check_eq("flush_ready", 32'(alloc_ready), 32'd1);
    wb_valid = 1'b1;
    wb_tag   = 4'd3;
    wb_val   = 32'hDEAD;
    $display("wb stale tag=3 val=0x0000dead");
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stale_no_commit", 32'(rob_valid), 32'd0);
      check_eq("stale_count", 32'(rob_count), 32'd0);
      tick();
    end
    do_alloc(5'd4, 1'b1, 32'h44);
    do_wb(0);
    wait_empty();

    // Reset in the middle of activity
    do_alloc(5'd8, 1'b1, 32'h88);
    do_alloc(5'd9, 1'b1, 32'h99);
    do_reset();
    check_eq("mid_rst_tag", 32'(alloc_tag), 32'd0);

    tick();
    tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_commit_buffer.md
Name: rob_commit_buffer

Overview:
- In-order reorder buffer. Accepts allocations from dispatch and out-of-order writebacks from execute.
- Retires at most one instruction per cycle, strictly in program order.
- Drives the commit write port (rob_valid, rob_dst_val, rob_dst_index) consumed by the architectural register file.
- Sits between dispatch/execute and the arch reg file. Provides a full-pipeline flush.

Parameters:
- NUM_ENTRIES, 16, ROB depth; power of two, >= 2.
- NUM_AREGS, 32, architectural register count; taken from CORE_PKG.
- TAG_W, $clog2(NUM_ENTRIES), ROB tag width (derived).
- AREG_W, $clog2(NUM_AREGS), arch register index width (derived).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_has_dst  in  1  instruction writes a destination register.
- alloc_dst_index  in  AREG_W  destination arch register.
- alloc_ready  out  1  an entry is available.
- alloc_tag  out  TAG_W  tag assigned to the current allocation (equals tail index).
- wb_valid  in  1  execute result valid.
- wb_tag  in  TAG_W  entry being completed.
- wb_val  in  32  result value.
- flush  in  1  discard all in-flight entries.
- rob_valid  out  1  commit write to arch reg file this cycle.
- rob_dst_val  out  32  committed value.
- rob_dst_index  out  AREG_W  committed destination.
- rob_count  out  TAG_W+1  occupied entries.

Behaviour:
- Per-entry state: valid, done, has_dst, dst_index, value[31:0].
- Pointers: head and tail, each TAG_W bits plus a wrap bit.
- Reset (asynchronous): all entries invalid, head=tail=0, rob_count=0, rob_valid=0, rob_dst_val=0, rob_dst_index=0.
- alloc_ready = (rob_count != NUM_ENTRIES). It is combinational on current state and does not look ahead to a same-cycle commit.
- alloc_tag = tail[TAG_W-1:0], combinational.
- Allocation fires on alloc_valid && alloc_ready at a clock edge:
  - entry[tail] gets valid=1, done=0, has_dst and dst_index captured;
  - tail increments modulo 2*NUM_ENTRIES, with the wrap bit toggling on index wrap.
- Writeback (wb_valid at an edge) sets entry[wb_tag].done=1 and value=wb_val.
  - A writeback to an invalid entry is ignored.
  - A second writeback to a done entry overwrites the value.
- Commit condition: entry[head].valid && entry[head].done, evaluated on registered state.
  - At that edge: head increments, entry[head].valid clears, and commit outputs register.
  - rob_valid <= has_dst && (dst_index != 0). Writes to x0 are suppressed.
  - rob_dst_val <= value; rob_dst_index <= dst_index.
  - Any edge without a commit: rob_valid <= 0. Value and index hold their last value.
- rob_valid is a single-cycle pulse per committed instruction. No backpressure from the arch reg file.
- Latency: writeback at edge N makes the entry done after N. If it is at head, commit happens at edge N+1 and rob_valid is high during cycle N+1..N+2. Allocate-to-earliest-commit is 2 edges.
- rob_count changes by +1 on alloc only, -1 on commit only, and 0 when both occur.
- Full: count==NUM_ENTRIES, head and tail indices equal, wrap bits differ. Empty: pointers fully equal.
- Simultaneous alloc and commit when not full: both occur.
- Simultaneous writeback and commit of a different entry: both occur.
- flush (synchronous, highest priority) takes effect at the next edge:
  - all valid bits clear, head=tail=0, rob_count=0, rob_valid<=0;
  - alloc and writeback in the same cycle are discarded;
  - no commit occurs in the flush cycle.
- Reset asserted mid-operation returns all state to reset values immediately, independent of clk.

Test Plan:
1. Reset then idle: rob_count=0, alloc_ready=1, alloc_tag=0, rob_valid=0 for 10 cycles.
2. Allocate x5, x6, x7 (tags 0,1,2). Writeback order tag2=0x33, tag0=0x11, tag1=0x22. Required commits on consecutive cycles: (5,0x11), (6,0x22), (7,0x33), with no commit before tag0 completes.
3. Allocate 16 with no writeback: alloc_ready=0 and rob_count=16. Then writeback tag0 and hold alloc_valid: no allocation in the commit cycle; the next cycle accepts it with alloc_tag=0 (wrap).
4. Run 40 alloc/writeback/commit cycles, one in flight at a time: tags cycle 0..15 twice-plus, and every commit value matches its writeback.
5. Allocate x0 with has_dst=1, and x9 with has_dst=0; writeback both. Both retire (rob_count decrements to 0) and rob_valid stays 0 throughout.
6. With 5 entries in flight, assert flush together with alloc_valid and wb_valid: the next cycle has rob_count=0, alloc_tag=0, rob_valid=0, and a later writeback to old tag 3 produces no commit.
